// File: rtl/counter_display_unit.sv
// -----------------------------------------------------------------------------
// counter_display_unit
//   Hex up/down counter driven by two debounced push buttons or by a divided
//   auto-count tick, with a time-multiplexed active-low seven-segment scanner.
//
// Ports
//   clk          in   sole clock, all state on the rising edge
//   reset        in   asynchronous active-low reset
//   inc, dec     in   raw asynchronous buttons, active-high
//   mode_select  in   00 manual up, 01 auto up, 10 manual up/down, 11 auto down
//   pause        in   freezes the auto tick divider while high
//   digit_select out  active-low one-hot digit enable [DIGITS]
//   seven        out  active-low segments {g,f,e,d,c,b,a}
//   count        out  current counter value [4*DIGITS]
//   overflow     out  one-cycle pulse on any attempt to step past a limit
// -----------------------------------------------------------------------------
module counter_display_unit #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 100000000,
    parameter int SCAN_DIV        = 100000,
    parameter bit SATURATE        = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic [1:0]            mode_select,
    input  logic                  pause,
    output logic [DIGITS-1:0]     digit_select,
    output logic [6:0]            seven,
    output logic [4*DIGITS-1:0]   count,
    output logic                  overflow
);

    localparam int CW  = 4 * DIGITS;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW  = $clog2(TICK_DIV + 1);
    localparam int SW  = $clog2(SCAN_DIV + 1);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ---------------- buttons: bit 0 = inc, bit 1 = dec ----------------
    logic [1:0]          w_btn_raw;
    logic [1:0]          r_sync1, r_sync2, r_acc, r_evt;
    logic [1:0][DBW-1:0] r_db_cnt;

    assign w_btn_raw = {dec, inc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_acc    <= '0;
            r_evt    <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int b = 0; b < 2; b++) begin
                r_evt[b] <= 1'b0;
                if (r_sync2[b] != r_acc[b]) begin
                    // Level has disagreed for DEBOUNCE_CYCLES cycles in a row:
                    // accept it; only a press (new level 1) raises an event.
                    if (r_db_cnt[b] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                        r_acc[b]    <= r_sync2[b];
                        r_db_cnt[b] <= '0;
                        r_evt[b]    <= r_sync2[b];
                    end else begin
                        r_db_cnt[b] <= r_db_cnt[b] + DBW'(1);
                    end
                end else begin
                    r_db_cnt[b] <= '0;
                end
            end
        end
    end

    // ---------------- auto-count tick divider ----------------
    logic [1:0]    r_mode_prev;
    logic [TW-1:0] r_tick_cnt;
    logic          w_auto, w_mode_chg, w_tick;

    assign w_auto     = mode_select[0];          // 01 and 11 are the auto modes
    assign w_mode_chg = (mode_select != r_mode_prev);
    assign w_tick     = w_auto && !pause && !w_mode_chg &&
                        (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_prev <= '0;
            r_tick_cnt  <= '0;
        end else begin
            r_mode_prev <= mode_select;
            if (w_mode_chg)
                r_tick_cnt <= '0;
            else if (w_auto && !pause)
                r_tick_cnt <= (r_tick_cnt == TW'(TICK_DIV - 1)) ? '0 : r_tick_cnt + TW'(1);
        end
    end

    // ---------------- counter ----------------
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_up, w_dn;

    always_comb begin
        w_up = 1'b0;
        w_dn = 1'b0;
        case (mode_select)
            2'b00: w_up = r_evt[0];
            2'b01: w_up = w_tick;
            2'b10: begin
                // Simultaneous inc and dec cancel out.
                w_up = r_evt[0] & ~r_evt[1];
                w_dn = r_evt[1] & ~r_evt[0];
            end
            default: w_dn = w_tick;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_up) begin
                if (&r_count) begin
                    r_ovf <= 1'b1;
                    if (SATURATE == 1'b0) r_count <= '0;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_dn) begin
                if (r_count == '0) begin
                    r_ovf <= 1'b1;
                    if (SATURATE == 1'b0) r_count <= '1;
                end else begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // ---------------- display scan ----------------
    logic [SW-1:0]           r_scan_cnt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [DIGITS-1:0]       r_digit_sel;
    logic [6:0]              r_seven;
    logic                    w_scan_step;
    logic [DIGITS-1:0][3:0]  w_nibbles;

    assign w_nibbles   = r_count;
    assign w_scan_step = (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_idx_nxt   = !w_scan_step ? r_idx :
                         (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

    // Enable and segments are both computed from the next index so they
    // change on the same edge and never show a digit with its neighbour's value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_digit_sel <= ~DIGITS'(1);
            r_seven     <= 7'b1000000;
        end else begin
            r_scan_cnt  <= w_scan_step ? '0 : r_scan_cnt + SW'(1);
            r_idx       <= w_idx_nxt;
            r_digit_sel <= ~(DIGITS'(1) << w_idx_nxt);
            r_seven     <= hex7(w_nibbles[w_idx_nxt]);
        end
    end

    assign digit_select = r_digit_sel;
    assign seven        = r_seven;
    assign count        = r_count;
    assign overflow     = r_ovf;

endmodule

// File: doc/counter_display_unit.md
COUNTER_DISPLAY_UNIT -- requirements
Module: counter_display_unit

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of hex digits counted and scanned (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, number of cycles a synchronised button level must hold stable before acceptance.
REQ-003 SHALL have parameter TICK_DIV, default 100000000, clk cycles per auto-count tick.
REQ-004 SHALL have parameter SCAN_DIV, default 100000, clk cycles per display digit step.
REQ-005 SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-006 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port inc  input  1  raw asynchronous up button, active-high.
REQ-009 SHALL have port dec  input  1  raw asynchronous down button, active-high.
REQ-010 SHALL have port mode_select  input  2  00 manual up, 01 auto up, 10 manual up/down, 11 auto down.
REQ-011 SHALL have port pause  input  1  freezes auto tick generation when high.
REQ-012 SHALL have port digit_select  output  DIGITS  active-low one-hot digit enable.
REQ-013 SHALL have port seven  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 SHALL have port count  output  4*DIGITS  current counter value.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse on any limit crossing attempt.

Function
REQ-016 SHALL pass inc and dec each through a 2-flop synchroniser before any other use.
REQ-017 SHALL debounce each synchronised button with its own counter: level differing from accepted state increments it, equal level clears it, reaching DEBOUNCE_CYCLES updates accepted state and clears it.
REQ-018 SHALL generate a one-cycle event only on accepted-state 0->1; release generates none.
REQ-019 SHALL use only clk for all state; dividers produce one-cycle enables, never derived clocks.
REQ-020 SHALL count a tick counter 0..TICK_DIV-1 in modes 01/11 while pause=0, emitting a tick enable on the wrap cycle; pause holds its value.
REQ-021 SHALL clear the tick counter on the cycle following any mode_select change.
REQ-022 SHALL step count: mode 00 +1 per inc event; 01 +1 per tick; 10 +1 per inc event, -1 per dec event; 11 -1 per tick; button events ignored in auto modes, dec ignored in mode 00.
REQ-023 SHALL leave count unchanged when inc and dec events coincide in mode 10.
REQ-024 SHALL, on up step at 2^(4*DIGITS)-1, go to 0 (SATURATE=0) or hold (SATURATE=1), and pulse overflow for one cycle in both cases.
REQ-025 SHALL, on down step at 0, go to 2^(4*DIGITS)-1 (SATURATE=0) or hold (SATURATE=1), and pulse overflow for one cycle.
REQ-026 SHALL update count on the clock edge after the event/tick cycle (1-cycle latency).
REQ-027 SHALL advance a scan index 0..DIGITS-1 (wrapping to 0) once per SCAN_DIV cycles; digit_select bit index low, others high.
REQ-028 SHALL drive seven as registered hex decode of count nibble [4*index+3:4*index], updated same edge as digit_select (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110).
REQ-029 SHALL keep scanning independent of mode, pause and counting.

Reset
REQ-030 SHALL, while reset=0, immediately force count=0, overflow=0, scan index=0, digit_select=all ones except bit 0 low, seven=1000000, all divider, debounce and synchroniser state to 0.
REQ-031 SHALL treat a button held across reset release as a new press once it passes debounce.
REQ-032 SHALL, on reset assertion mid-debounce or mid-tick, discard the partial count with no event.

Verification (DIGITS=4, DEBOUNCE_CYCLES=4, TICK_DIV=10, SCAN_DIV=3)
REQ-033 SHALL test: mode 00, inc high 20 cycles -> count 0x0001 exactly once; inc glitch of 3 cycles -> no change.
REQ-034 SHALL test: mode 01, pause=0, 100 cycles from reset -> count 0x000A; pause 30 cycles mid-run -> count frozen throughout.
REQ-035 SHALL test: mode 10, count 0x0000, dec press -> count 0xFFFF and overflow one cycle; SATURATE=1 repeat -> count 0x0000, overflow pulsed.
REQ-036 SHALL test: mode 10, inc and dec pressed same cycle -> count unchanged, overflow 0.
REQ-037 SHALL test: count 0x12AF, scan -> digit_select 1110/1101/1011/0111 each 3 cycles with seven 0001110/0001000/0100100/1111001, then wraps.
REQ-038 SHALL test: reset pulsed low asynchronously mid-count -> all outputs at REQ-030 values before next clk edge.
